// File: rtl/square_wave_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : square_wave_arbiter
// Description : Round-robin arbiter that lends one shared square-wave
//               generator to NUM_REQ requesters. The winner's half-period
//               and period count are captured at grant time. The burst
//               is then played out on square_wave, and done pulses to the
//               winner on the first cycle back in IDLE.
// Ports       : clk          - system clock, rising edge
//               rst_n        - asynchronous active-low reset
//               req          - per-requester burst request (level)
//               half_period  - flattened, slice i = requester i half-period
//               num_cycles   - flattened, slice i = requester i period count
//               grant        - one-hot, high for the whole winning burst
//               done         - one-cycle pulse to the winner at burst end
//               busy         - high while a burst is running
//               square_wave  - shared generated waveform
// Revision    : 1.0 - initial release
// ============================================================================
module square_wave_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 32,
    parameter int PULSE_W = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*CNT_W-1:0]   half_period,
    input  logic [NUM_REQ*PULSE_W-1:0] num_cycles,
    output logic [NUM_REQ-1:0]         grant,
    output logic [NUM_REQ-1:0]         done,
    output logic                       busy,
    output logic                       square_wave
);

    localparam int c_ptr_w = $clog2(NUM_REQ);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t               r_state, w_state;
    logic [c_ptr_w-1:0]   r_ptr,   w_ptr;
    logic [CNT_W-1:0]     r_h,     w_h;
    logic [PULSE_W-1:0]   r_n,     w_n;
    logic [CNT_W-1:0]     r_cnt,   w_cnt;
    logic [PULSE_W:0]     r_tog,   w_tog;
    logic [NUM_REQ-1:0]   r_grant, w_grant;
    logic [NUM_REQ-1:0]   r_done,  w_done;
    logic                 r_busy,  w_busy;
    logic                 r_sq,    w_sq;

    logic [CNT_W-1:0]     w_hp [NUM_REQ];
    logic [PULSE_W-1:0]   w_nc [NUM_REQ];
    logic [c_ptr_w-1:0]   w_sel;
    logic                 w_any;
    logic [CNT_W-1:0]     w_hp_sel;
    logic [PULSE_W-1:0]   w_nc_sel;
    logic [PULSE_W:0]     w_tog_last;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
        assign w_hp[gi] = half_period[gi*CNT_W +: CNT_W];
        assign w_nc[gi] = num_cycles[gi*PULSE_W +: PULSE_W];
    end

    assign w_any    = |req;
    assign w_hp_sel = w_hp[w_sel];
    assign w_nc_sel = w_nc[w_sel];

    // Index of the final toggle of a burst: toggle number 2N happens when
    // the count of completed toggles is 2N-1. The extra bit keeps 2N exact.
    assign w_tog_last = {r_n, 1'b0} - (PULSE_W+1)'(1);

    // Round-robin search from ptr+1 upward with wrap. Walking the offsets
    // from farthest to nearest lets the nearest set request win last.
    always_comb begin
        w_sel = r_ptr;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (req[(int'(r_ptr) + k) % NUM_REQ]) begin
                w_sel = c_ptr_w'((int'(r_ptr) + k) % NUM_REQ);
            end
        end
    end

    always_comb begin
        w_state = r_state;
        w_ptr   = r_ptr;
        w_h     = r_h;
        w_n     = r_n;
        w_cnt   = r_cnt;
        w_tog   = r_tog;
        w_grant = r_grant;
        w_done  = '0;
        w_busy  = r_busy;
        w_sq    = r_sq;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_state = ST_RUN;
                    w_ptr   = w_sel;
                    w_grant = NUM_REQ'(1) << w_sel;
                    // A zero half-period would never match cnt == H-1.
                    w_h     = (w_hp_sel == '0) ? CNT_W'(1) : w_hp_sel;
                    w_n     = w_nc_sel;
                    w_cnt   = '0;
                    w_tog   = '0;
                    w_busy  = 1'b1;
                    w_sq    = (w_nc_sel != '0);
                end
            end
            ST_RUN: begin
                if ((r_n == '0) ||
                    ((r_cnt == r_h - CNT_W'(1)) && (r_tog == w_tog_last))) begin
                    // Burst complete: done goes to whoever holds the grant.
                    w_state = ST_IDLE;
                    w_done  = r_grant;
                    w_grant = '0;
                    w_busy  = 1'b0;
                    w_sq    = 1'b0;
                    w_cnt   = '0;
                    w_tog   = '0;
                end else if (r_cnt == r_h - CNT_W'(1)) begin
                    w_sq  = ~r_sq;
                    w_cnt = '0;
                    w_tog = r_tog + (PULSE_W+1)'(1);
                end else begin
                    w_cnt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            // Pointing at the last index gives requester 0 first priority.
            r_ptr   <= c_ptr_w'(NUM_REQ - 1);
            r_h     <= '0;
            r_n     <= '0;
            r_cnt   <= '0;
            r_tog   <= '0;
            r_grant <= '0;
            r_done  <= '0;
            r_busy  <= 1'b0;
            r_sq    <= 1'b0;
        end else begin
            r_state <= w_state;
            r_ptr   <= w_ptr;
            r_h     <= w_h;
            r_n     <= w_n;
            r_cnt   <= w_cnt;
            r_tog   <= w_tog;
            r_grant <= w_grant;
            r_done  <= w_done;
            r_busy  <= w_busy;
            r_sq    <= w_sq;
        end
    end

    assign grant       = r_grant;
    assign done        = r_done;
    assign busy        = r_busy;
    assign square_wave = r_sq;

endmodule
`default_nettype wire

// File: tb/tb_square_wave_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_square_wave_arbiter
// Description : Scoreboard bench for square_wave_arbiter. Stimulus pushes
//               the expected burst (winner, length, high cycles, rising
//               edges, first high-run length) into a queue. A monitor
//               measures each burst and compares it when done pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_square_wave_arbiter;

    localparam int NUM_REQ = 4;
    localparam int CNT_W   = 32;
    localparam int PULSE_W = 16;

    logic                       clk = 1'b0;
    logic                       rst_n = 1'b0;
    logic [NUM_REQ-1:0]         req = '0;
    logic [NUM_REQ*CNT_W-1:0]   half_period = '0;
    logic [NUM_REQ*PULSE_W-1:0] num_cycles = '0;
    logic [NUM_REQ-1:0]         grant;
    logic [NUM_REQ-1:0]         done;
    logic                       busy;
    logic                       square_wave;

    square_wave_arbiter #(
        .NUM_REQ (NUM_REQ),
        .CNT_W   (CNT_W),
        .PULSE_W (PULSE_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .half_period (half_period),
        .num_cycles  (num_cycles),
        .grant       (grant),
        .done        (done),
        .busy        (busy),
        .square_wave (square_wave)
    );

    always #5 clk = ~clk;

    typedef struct {
        int idx;
        int len;
        int highs;
        int rises;
        int first;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int onehot_idx(input logic [NUM_REQ-1:0] v);
        int r = -1;
        for (int i = 0; i < NUM_REQ; i++) if (v[i]) r = i;
        return r;
    endfunction

    // Expected burst for requester idx with half-period h and n periods.
    function automatic void push(input int idx, input int h, input int n);
        exp_t e;
        int   he = (h == 0) ? 1 : h;
        e.idx   = idx;
        e.len   = (n == 0) ? 1 : 2 * n * he;
        e.highs = n * he;
        e.rises = n;
        e.first = (n == 0) ? 0 : he;
        q.push_back(e);
    endfunction

    task automatic set_cfg(input int i, input int h, input int n);
        half_period[i*CNT_W +: CNT_W]     = CNT_W'(h);
        num_cycles[i*PULSE_W +: PULSE_W]  = PULSE_W'(n);
    endtask

    task automatic wait_grant(input logic [NUM_REQ-1:0] mask, input int budget);
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (grant == mask) return;
        end
        check("grant_timeout", int'(grant), int'(mask));
    endtask

    task automatic wait_dones(input int k, input int budget);
        int seen = 0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (done != '0) seen++;
            if (seen >= k) return;
        end
        check("done_timeout", seen, k);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- monitor ----------------
    logic in_burst = 1'b0;
    logic prev_sq  = 1'b0;
    int   cur_idx, b_len, b_highs, b_rises, b_first;

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            in_burst = 1'b0;
        end else begin
            if (grant != '0) begin
                if (!in_burst) begin
                    in_burst = 1'b1;
                    cur_idx  = onehot_idx(grant);
                    b_len = 0; b_highs = 0; b_rises = 0; b_first = 0;
                    prev_sq  = 1'b0;
                end
                b_len++;
                if (square_wave) begin
                    b_highs++;
                    if (!prev_sq) b_rises++;
                    if (b_rises == 1) b_first++;
                end
                prev_sq = square_wave;
            end
            if ($countones(grant) > 1 || $countones(done) > 1 || (!busy && square_wave))
                check("invariant", 1, 0);
            if (done != '0) begin
                if (q.size() == 0) begin
                    check("unexpected_done", onehot_idx(done), -1);
                end else begin
                    e = q.pop_front();
                    check("done_idx",      onehot_idx(done), e.idx);
                    check("burst_idx",     cur_idx,          e.idx);
                    check("burst_len",     b_len,            e.len);
                    check("burst_highs",   b_highs,          e.highs);
                    check("burst_rises",   b_rises,          e.rises);
                    check("burst_first",   b_first,          e.first);
                    check("grant_at_done", int'(grant),      0);
                    check("busy_at_done",  int'(busy),       0);
                    check("sq_at_done",    int'(square_wave), 0);
                end
                in_burst = 1'b0;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        check("rst_grant", int'(grant), 0);
        check("rst_done",  int'(done), 0);
        check("rst_busy",  int'(busy), 0);
        check("rst_sq",    int'(square_wave), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single requester H=3 N=2.
        set_cfg(0, 3, 2);
        push(0, 3, 2);
        req = 4'b0001;
        @(posedge clk);
        #1;
        check("t1_grant_first", int'(grant), 1);
        check("t1_sq_first",    int'(square_wave), 1);
        req = 4'b0000;
        wait_dones(1, 100);

        // All four held, H=1 N=1: order 0,1,2,3,0.
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) set_cfg(i, 1, 1);
        push(0, 1, 1); push(1, 1, 1); push(2, 1, 1); push(3, 1, 1); push(0, 1, 1);
        req = 4'b1111;
        wait_dones(5, 100);
        req = 4'b0000;

        // H=0 behaves as H=1.
        set_cfg(1, 0, 3);
        push(1, 0, 3);
        req = 4'b0010;
        wait_grant(4'b0010, 20);
        req = 4'b0000;
        wait_dones(1, 100);

        // N=0: one-cycle grant, no waveform.
        set_cfg(2, 5, 0);
        push(2, 5, 0);
        req = 4'b0100;
        wait_grant(4'b0100, 20);
        req = 4'b0000;
        wait_dones(1, 100);

        // Mid-burst input changes are ignored.
        set_cfg(0, 4, 3);
        push(0, 4, 3);
        req = 4'b0001;
        wait_grant(4'b0001, 20);
        req = 4'b0000;
        repeat (5) @(negedge clk);
        set_cfg(0, 9, 7);
        wait_dones(1, 200);

        // Reset at the mid-point of an H=5 N=4 burst.
        set_cfg(1, 5, 4);
        req = 4'b0010;
        wait_grant(4'b0010, 20);
        req = 4'b0000;
        repeat (19) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_sq",    int'(square_wave), 0);
        check("mid_rst_grant", int'(grant), 0);
        check("mid_rst_busy",  int'(busy), 0);
        check("mid_rst_done",  int'(done), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        set_cfg(0, 2, 1);
        set_cfg(2, 2, 1);
        push(0, 2, 1); push(2, 2, 1);
        req = 4'b0101;
        wait_dones(2, 100);
        req = 4'b0000;

        // Fairness: 1 and 3 held, 2 pulsed once.
        do_reset();
        set_cfg(1, 1, 2); set_cfg(2, 1, 2); set_cfg(3, 1, 2);
        push(1, 1, 2); push(2, 1, 2); push(3, 1, 2); push(1, 1, 2);
        req = 4'b1110;
        wait_grant(4'b0100, 50);
        req = 4'b1010;
        wait_dones(3, 100);
        req = 4'b0000;

        repeat (5) @(negedge clk);
        check("queue_empty", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/square_wave_arbiter.md
# square_wave_arbiter

Shares one square-wave generator between `NUM_REQ` requesters. Each requester asks for a burst defined by a half-period count and a number of full periods. A round-robin arbiter grants one requester at a time, captures that requester's settings, and drives the shared `square_wave` output for the burst. It then signals completion to the winner. It sits between the tone/pulse clients and the output pin, replacing fixed-frequency dividers where several clients need the same output.

## Interface
- `NUM_REQ`, default 4: number of requesters (2..16).
- `CNT_W`, default 32: width of a half-period count, in clk cycles.
- `PULSE_W`, default 16: width of a period-count field.

- `clk`  in  1  system clock; all logic runs on its rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `req`  in  NUM_REQ  per-requester burst request, level-sensitive.
- `half_period`  in  NUM_REQ*CNT_W  flattened; slice i holds requester i's half-period in clk cycles.
- `num_cycles`  in  NUM_REQ*PULSE_W  flattened; slice i holds requester i's number of full periods.
- `grant`  out  NUM_REQ  one-hot; high for the whole burst of the winning requester.
- `done`  out  NUM_REQ  one-cycle pulse to the winner when its burst ends.
- `busy`  out  1  high while in RUN.
- `square_wave`  out  1  the shared generated waveform.

## Operation
- States are IDLE and RUN. Registers:
  - `ptr`: last granted index.
  - `H`: captured half-period; 0 is treated as 1.
  - `N`: captured number of periods.
  - `cnt`: CNT_W bits.
  - `tog`: PULSE_W+1 bits, so that 2*N never overflows.
- IDLE behaviour:
  - If any `req` bit is high, select the first set index searching `ptr+1, ptr+2, …` with wrap-around modulo NUM_REQ.
  - On the same edge: set `grant[i]`, set `ptr <= i`, capture H and N from slice i, set `cnt <= 0` and `tog <= 0`, set `busy <= 1`, go to RUN.
  - If N = 0, `square_wave` stays 0; otherwise `square_wave <= 1`.
- RUN behaviour, per edge:
  - If N = 0: pulse `done[i]`, clear `grant` and `busy`, go to IDLE.
  - Otherwise, if `cnt == H-1`: toggle `square_wave`, set `cnt <= 0`, set `tog <= tog+1`.
  - If that toggle is number 2*N (`tog == 2N-1` before the increment): on the same edge `square_wave` becomes 0, `done[i]` pulses, `grant` and `busy` clear, and the state returns to IDLE.
  - Otherwise `cnt <= cnt+1`.
- Inputs are captured only at grant time:
  - Changes to `req`, `half_period` or `num_cycles` during RUN are ignored.
  - Dropping `req[i]` mid-burst does not abort the burst.
- A requester that drops `req` before being granted is simply not selected.
- `done[i]` is asserted only for the requester that currently holds the grant. At most one `done` bit and at most one `grant` bit are high at any time.
- `square_wave` is 0 whenever the block is in IDLE.

## Timing
- Reset, asynchronous on `rst_n` low: state IDLE, `grant = 0`, `done = 0`, `busy = 0`, `square_wave = 0`, `cnt = 0`, `tog = 0`, `ptr = NUM_REQ-1` so that requester 0 has first priority.
  - A reset asserted mid-burst clears all outputs immediately. No `done` pulse is issued for the interrupted burst.
- If `req` is high at edge E in IDLE, `grant` and `square_wave` go high after edge E.
- A burst with N ≥ 1 occupies exactly 2·N·max(H,1) cycles in RUN:
  - `square_wave` is high for H cycles, then low for H cycles, repeated N times.
  - The `done` pulse coincides with the first cycle back in IDLE. `grant` is low in that same cycle.
- Gap between bursts: one IDLE cycle minimum, during which `square_wave` is low. The next grant is visible in the following cycle.
- A burst with N = 0 asserts `grant` for one cycle, then `done` pulses. `square_wave` never rises.
- Output period is 2·H·T_clk. For example, 50 MHz with H = 1 250 000 gives 20 Hz.

## Test plan
- Single requester, H=3, N=2, `req[0]` raised at cycle 0:
  - `grant = 0001` from cycle 1.
  - `square_wave` pattern 111000111000 over cycles 1–12.
  - `done[0]` pulses at cycle 13, `busy` is low at cycle 13.
- All four `req` held high, H=1, N=1:
  - Grants occur in order 0,1,2,3,0, each lasting 2 cycles with a 1-cycle IDLE gap.
  - `done` bits pulse in the same order.
- Edge cases:
  - H=0 behaves identically to H=1: `square_wave` toggles every cycle.
  - N=0: `grant` high for 1 cycle, `done` pulses, `square_wave` stays 0 throughout.
- Input changes mid-burst (H=4, N=3): change `half_period[0]` to 9 and drop `req[0]` during RUN.
  - The waveform still uses H=4 for all 3 periods.
  - `done[0]` still pulses.
- `rst_n` pulled low at the mid-point of an H=5, N=4 burst:
  - `square_wave`, `grant`, `busy` and `done` go to 0 immediately.
  - After release, `req[2]` high with `req[0]` high results in requester 0 being granted first.
- Round-robin fairness: hold `req[1]` and `req[3]` constantly high with `req[2]` pulsed in between.
  - Grant sequence is 1, 2, 3, 1, …
  - No requester waits more than NUM_REQ−1 bursts.
